// File: rtl/sync_fsm_if.sv
// Signal bundle between the preamble comparator side and the sync_fsm core.
// The master drives the sample controls; the slave is the FSM that reports status.
interface sync_fsm_if #(
  parameter int CNT_W = 8
) ();
  logic             en;
  logic             is_matching;
  logic             rearm;
  logic             is_waiting;
  logic             is_waiting_ending;
  logic             is_running;
  logic             run_start;
  logic             abort;
  logic [CNT_W-1:0] run_cnt;

  modport master (
    output en, is_matching, rearm,
    input  is_waiting, is_waiting_ending, is_running, run_start, abort, run_cnt
  );

  modport slave (
    input  en, is_matching, rearm,
    output is_waiting, is_waiting_ending, is_running, run_start, abort, run_cnt
  );
endinterface

// File: rtl/sync_fsm.sv
// Preamble synchroniser: qualifies MIN_MATCH..MAX_MATCH consecutive matching
// samples, then runs for RUN_LEN enabled cycles (or forever when RUN_LEN = 0).
// Level outputs are decoded from the state register; run_start/abort are
// registered single-cycle pulses.
module sync_fsm #(
  parameter int CNT_W     = 8,
  parameter int MIN_MATCH = 4,
  parameter int MAX_MATCH = 16,
  parameter int RUN_LEN   = 0
) (
  input  logic     clk,
  input  logic     rst_n,
  sync_fsm_if.slave bus
);

  localparam logic [1:0] WAITING        = 2'd0;
  localparam logic [1:0] MATCHING       = 2'd1;
  localparam logic [1:0] WAITING_ENDING = 2'd2;
  localparam logic [1:0] RUNNING        = 2'd3;

  localparam logic [CNT_W-1:0] MIN_C    = CNT_W'(MIN_MATCH);
  localparam logic [CNT_W-1:0] MAX_C    = CNT_W'(MAX_MATCH);
  localparam logic [CNT_W-1:0] ONE_C    = CNT_W'(1);
  localparam logic [CNT_W-1:0] CNT_MAX  = '1;
  // Last run_cnt value before leaving RUNNING; only meaningful when RUN_LEN != 0.
  localparam logic [CNT_W-1:0] RUN_LAST = (RUN_LEN == 0) ? '0 : CNT_W'(RUN_LEN - 1);

  logic [1:0]       state, state_nx;
  logic [CNT_W-1:0] match_cnt, match_nx, match_inc;
  logic [CNT_W-1:0] run_cnt, run_nx;
  logic             run_start, run_start_nx;
  logic             abort, abort_nx;

  assign match_inc = match_cnt + ONE_C;

  // Next-state and counter logic: rearm beats the en=0 hold, which beats transitions.
  always_comb begin
    // NOTE: every output of this block gets a default first so no path leaves
    // it unassigned; otherwise synthesis infers latches.
    state_nx     = state;
    match_nx     = match_cnt;
    run_nx       = run_cnt;
    run_start_nx = 1'b0;
    abort_nx     = 1'b0;

    if (bus.rearm) begin
      state_nx = WAITING;
      match_nx = '0;
      run_nx   = '0;
    end else if (bus.en) begin
      case (state)
        WAITING: begin
          if (bus.is_matching) begin
            match_nx = ONE_C;
            state_nx = (MIN_MATCH == 1) ? WAITING_ENDING : MATCHING;
          end else begin
            match_nx = '0;
          end
        end
        MATCHING: begin
          if (bus.is_matching) begin
            match_nx = match_inc;
            if (match_inc == MIN_C) state_nx = WAITING_ENDING;
          end else begin
            state_nx = WAITING;
            match_nx = '0;
          end
        end
        WAITING_ENDING: begin
          if (bus.is_matching) begin
            // Too long a preamble is treated as a false lock and dropped.
            if (match_cnt >= MAX_C) begin
              state_nx = WAITING;
              match_nx = '0;
              abort_nx = 1'b1;
            end else begin
              match_nx = match_inc;
            end
          end else begin
            state_nx     = RUNNING;
            match_nx     = '0;
            run_nx       = '0;
            run_start_nx = 1'b1;
          end
        end
        RUNNING: begin
          if ((RUN_LEN != 0) && (run_cnt == RUN_LAST)) begin
            state_nx = WAITING;
            run_nx   = '0;
          end else if (run_cnt != CNT_MAX) begin
            run_nx = run_cnt + ONE_C;
          end
        end
        default: begin
          state_nx = WAITING;
          match_nx = '0;
          run_nx   = '0;
        end
      endcase
    end
  end

  // State, counter and pulse registers with asynchronous reset to WAITING.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state     <= WAITING;
      match_cnt <= '0;
      run_cnt   <= '0;
      run_start <= 1'b0;
      abort     <= 1'b0;
    end else begin
      // NOTE: registers take non-blocking assignments so every flop samples
      // the pre-edge values regardless of statement order.
      state     <= state_nx;
      match_cnt <= match_nx;
      run_cnt   <= run_nx;
      run_start <= run_start_nx;
      abort     <= abort_nx;
    end
  end

  assign bus.is_waiting        = (state == WAITING) || (state == MATCHING);
  assign bus.is_waiting_ending = (state == WAITING_ENDING);
  assign bus.is_running        = (state == RUNNING);
  assign bus.run_start         = run_start;
  assign bus.abort             = abort;
  assign bus.run_cnt           = (state == RUNNING) ? run_cnt : '0;

endmodule

// File: tb/tb_sync_fsm.sv
// Self-checking bench for sync_fsm: a vector table for the default-style build
// (MIN_MATCH=4, MAX_MATCH=16, RUN_LEN=8) plus hand-written sequences for the
// asynchronous reset and the MIN_MATCH=1 / RUN_LEN=0 saturating build.
module tb_sync_fsm;

  localparam logic [2:0] ST_W = 3'b100;  // is_waiting
  localparam logic [2:0] ST_E = 3'b010;  // is_waiting_ending
  localparam logic [2:0] ST_R = 3'b001;  // is_running

  typedef struct {
    logic       en;
    logic       m;
    logic       rearm;
    logic [2:0] st;
    logic       rs;
    logic       ab;
    logic [7:0] cnt;
  } vec_t;

  logic clk;
  logic rst_n;
  int   n_checks;
  int   n_errors;
  vec_t vecs[$];

  sync_fsm_if #(.CNT_W(8)) a_if ();
  sync_fsm_if #(.CNT_W(8)) b_if ();

  sync_fsm #(.CNT_W(8), .MIN_MATCH(4), .MAX_MATCH(16), .RUN_LEN(8)) dut_a (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (a_if)
  );

  sync_fsm #(.CNT_W(8), .MIN_MATCH(1), .MAX_MATCH(16), .RUN_LEN(0)) dut_b (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (b_if)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  function automatic logic [12:0] act_a();
    return {a_if.is_waiting, a_if.is_waiting_ending, a_if.is_running,
            a_if.run_start, a_if.abort, a_if.run_cnt};
  endfunction

  function automatic logic [12:0] act_b();
    return {b_if.is_waiting, b_if.is_waiting_ending, b_if.is_running,
            b_if.run_start, b_if.abort, b_if.run_cnt};
  endfunction

  task automatic check(input string name, input logic [12:0] act, input logic [12:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_errors++;
      $display("FAIL %s: got w/we/r=%b rs=%b ab=%b cnt=%0d, expected w/we/r=%b rs=%b ab=%b cnt=%0d",
               name, act[12:10], act[9], act[8], act[7:0], exp[12:10], exp[9], exp[8], exp[7:0]);
    end
  endtask

  function automatic void add(input logic en, input logic m, input logic rearm,
                              input logic [2:0] st, input logic rs, input logic ab,
                              input logic [7:0] cnt);
    vec_t v;
    v.en = en; v.m = m; v.rearm = rearm; v.st = st; v.rs = rs; v.ab = ab; v.cnt = cnt;
    vecs.push_back(v);
  endfunction

  task automatic step_b(input logic en, input logic m, input logic rearm);
    b_if.en = en; b_if.is_matching = m; b_if.rearm = rearm;
    @(posedge clk);
    #1;
  endtask

  initial begin
    n_checks = 0;
    n_errors = 0;

    // 4 matches then 0: RUNNING for 8 cycles with run_cnt 0..7.
    for (int i = 0; i < 3; i++) add(1, 1, 0, ST_W, 0, 0, 0);
    add(1, 1, 0, ST_E, 0, 0, 0);
    add(1, 0, 0, ST_R, 1, 0, 0);
    for (int k = 1; k < 8; k++) add(1, 0, 0, ST_R, 0, 0, 8'(k));
    add(1, 0, 0, ST_W, 0, 0, 0);
    // 3 matches then 0: never qualifies.
    for (int i = 0; i < 3; i++) add(1, 1, 0, ST_W, 0, 0, 0);
    add(1, 0, 0, ST_W, 0, 0, 0);
    add(1, 0, 0, ST_W, 0, 0, 0);
    // 17 matches: abort after edge 17, single-cycle.
    for (int i = 0; i < 3; i++) add(1, 1, 0, ST_W, 0, 0, 0);
    for (int i = 4; i <= 16; i++) add(1, 1, 0, ST_E, 0, 0, 0);
    add(1, 1, 0, ST_W, 0, 1, 0);
    add(1, 0, 0, ST_W, 0, 0, 0);
    // 16 matches then 0: runs; rearm at run_cnt=3.
    for (int i = 0; i < 3; i++) add(1, 1, 0, ST_W, 0, 0, 0);
    for (int i = 4; i <= 16; i++) add(1, 1, 0, ST_E, 0, 0, 0);
    add(1, 0, 0, ST_R, 1, 0, 0);
    for (int k = 1; k <= 3; k++) add(1, 0, 0, ST_R, 0, 0, 8'(k));
    add(1, 0, 1, ST_W, 0, 0, 0);
    add(0, 0, 0, ST_W, 0, 0, 0);
    // rearm with en=0 in WAITING_ENDING still returns to WAITING and clears match_cnt.
    for (int i = 0; i < 3; i++) add(1, 1, 0, ST_W, 0, 0, 0);
    add(1, 1, 0, ST_E, 0, 0, 0);
    add(0, 1, 1, ST_W, 0, 0, 0);
    add(1, 0, 0, ST_W, 0, 0, 0);
    // en toggling: matching and run advance only on en=1 edges.
    for (int i = 0; i < 3; i++) begin
      add(1, 1, 0, ST_W, 0, 0, 0);
      add(0, 0, 0, ST_W, 0, 0, 0);
    end
    add(1, 1, 0, ST_E, 0, 0, 0);
    add(0, 0, 0, ST_E, 0, 0, 0);
    add(1, 0, 0, ST_R, 1, 0, 0);
    add(0, 1, 0, ST_R, 0, 0, 0);
    for (int k = 1; k < 8; k++) begin
      add(1, 1, 0, ST_R, 0, 0, 8'(k));
      add(0, 0, 0, ST_R, 0, 0, 8'(k));
    end
    add(1, 0, 0, ST_W, 0, 0, 0);

    a_if.en = 1'b0; a_if.is_matching = 1'b0; a_if.rearm = 1'b0;
    b_if.en = 1'b0; b_if.is_matching = 1'b0; b_if.rearm = 1'b0;
    rst_n = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    check("reset_a", act_a(), {ST_W, 1'b0, 1'b0, 8'd0});
    check("reset_b", act_b(), {ST_W, 1'b0, 1'b0, 8'd0});
    @(negedge clk);
    rst_n = 1'b1;

    for (int i = 0; i < vecs.size(); i++) begin
      a_if.en = vecs[i].en; a_if.is_matching = vecs[i].m; a_if.rearm = vecs[i].rearm;
      @(posedge clk);
      #1;
      check($sformatf("vec%0d", i), act_a(), {vecs[i].st, vecs[i].rs, vecs[i].ab, vecs[i].cnt});
    end

    // Asynchronous reset in RUNNING takes effect without a clock edge.
    a_if.en = 1'b1; a_if.rearm = 1'b0; a_if.is_matching = 1'b1;
    repeat (4) @(posedge clk);
    #1;
    a_if.is_matching = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    check("run_before_rst", act_a(), {ST_R, 1'b0, 1'b0, 8'd2});
    #2;
    rst_n = 1'b0;
    #1;
    check("async_rst", act_a(), {ST_W, 1'b0, 1'b0, 8'd0});
    @(posedge clk);
    #1;
    check("rst_held", act_a(), {ST_W, 1'b0, 1'b0, 8'd0});
    @(negedge clk);
    rst_n = 1'b1;
    @(posedge clk);
    #1;
    check("after_rst", act_a(), {ST_W, 1'b0, 1'b0, 8'd0});
    a_if.en = 1'b0;

    // MIN_MATCH=1, RUN_LEN=0 build: runs after 2 edges and saturates at 255.
    step_b(1, 1, 0);
    check("b_match1", act_b(), {ST_E, 1'b0, 1'b0, 8'd0});
    step_b(1, 0, 0);
    check("b_run_start", act_b(), {ST_R, 1'b1, 1'b0, 8'd0});
    for (int k = 1; k <= 300; k++) begin
      step_b(1, k[0], 0);
      check($sformatf("b_run%0d", k), act_b(), {ST_R, 1'b0, 1'b0, (k > 255) ? 8'd255 : 8'(k)});
    end
    step_b(0, 0, 0);
    check("b_hold", act_b(), {ST_R, 1'b0, 1'b0, 8'd255});
    step_b(1, 0, 1);
    check("b_rearm", act_b(), {ST_W, 1'b0, 1'b0, 8'd0});

    $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
    $finish;
  end

endmodule

// File: doc/sync_fsm.md
SYNC_FSM -- requirements
Module: sync_fsm

Interface
REQ-001 Parameter CNT_W, default 8, width of internal match and run counters and of run_cnt.
REQ-002 Parameter MIN_MATCH, default 4, consecutive matching cycles required to qualify a preamble.
REQ-003 Parameter MAX_MATCH, default 16, maximum consecutive matching cycles tolerated before abort.
REQ-004 Parameter RUN_LEN, default 0, run duration in enabled cycles; 0 means run until rearm or reset.
REQ-005 Legal parameters SHALL satisfy 1 <= MIN_MATCH <= MAX_MATCH <= 2^CNT_W-1 and RUN_LEN <= 2^CNT_W-1; anything else is unsupported.
REQ-006 clk  input  1  single clock; all state updates on its rising edge.
REQ-007 rst_n  input  1  reset, asynchronous assertion, active-low.
REQ-008 en  input  1  sample enable; when low, the block holds its state.
REQ-009 is_matching  input  1  per-sample preamble match flag from the upstream comparator.
REQ-010 rearm  input  1  synchronous request to return to WAITING.
REQ-011 is_waiting  output  1  high in WAITING or MATCHING.
REQ-012 is_waiting_ending  output  1  high in WAITING_ENDING.
REQ-013 is_running  output  1  high in RUNNING.
REQ-014 run_start  output  1  one-cycle pulse, high in the first cycle of RUNNING.
REQ-015 abort  output  1  one-cycle pulse, high in the cycle after a MAX_MATCH overrun.
REQ-016 run_cnt  output  CNT_W  enabled cycles elapsed in RUNNING, 0 outside RUNNING.

Function
REQ-017 The block SHALL implement four states: WAITING, MATCHING, WAITING_ENDING and RUNNING.
REQ-018 The level outputs SHALL be decoded from the state register only (Moore); exactly one of is_waiting, is_waiting_ending and is_running SHALL be high at any time.
REQ-019 Inputs SHALL be sampled at the rising clk edge; a state change SHALL be visible on the outputs one cycle after the qualifying sample.
REQ-020 Rule precedence: rearm first, then en=0 hold, then the state transitions below.
REQ-021 rearm=1 at an edge, in any state and regardless of en, SHALL go to WAITING, clear match_cnt and run_cnt, and suppress both pulses.
REQ-022 When en=0 and rearm=0, the state and counters SHALL hold and run_start/abort SHALL be 0.
REQ-023 WAITING: is_matching=1 sets match_cnt=1 and goes to WAITING_ENDING if MIN_MATCH=1, else to MATCHING; is_matching=0 stays, match_cnt=0.
REQ-024 MATCHING: is_matching=1 increments match_cnt and goes to WAITING_ENDING when the new value equals MIN_MATCH; is_matching=0 goes to WAITING, match_cnt=0, no pulse.
REQ-025 WAITING_ENDING with is_matching=1: if match_cnt < MAX_MATCH, increment match_cnt and stay; if match_cnt = MAX_MATCH, go to WAITING, clear match_cnt and pulse abort.
REQ-026 WAITING_ENDING with is_matching=0: go to RUNNING, set run_cnt=0, pulse run_start, clear match_cnt.
REQ-027 RUNNING ignores is_matching and increments run_cnt on every enabled cycle.
REQ-028 If RUN_LEN != 0 and run_cnt = RUN_LEN-1 at an enabled edge, the block SHALL go to WAITING with run_cnt=0, so RUNNING lasts exactly RUN_LEN enabled cycles.
REQ-029 If RUN_LEN = 0, run_cnt SHALL saturate at 2^CNT_W-1 and never wrap; the block stays in RUNNING.
REQ-030 match_cnt SHALL never exceed MAX_MATCH and never wrap.
REQ-031 An unreachable state encoding SHALL go to WAITING on the next edge with counters cleared.

Reset
REQ-032 rst_n=0 SHALL immediately force WAITING, match_cnt=0 and run_cnt=0, giving is_waiting=1, all other outputs 0; this holds mid-operation, including in RUNNING.
REQ-033 Release of rst_n SHALL be synchronised to clk by the integrating level; the first sample is taken at the first edge with rst_n=1.

Verification (MIN_MATCH=4, MAX_MATCH=16, RUN_LEN=8, en=1 unless stated)
REQ-034 4 matching cycles then is_matching=0 -> is_waiting_ending=1 after the 4th edge; run_start=1 for one cycle after the 5th edge; is_running=1 for exactly 8 cycles with run_cnt 0..7; then is_waiting=1.
REQ-035 3 matching cycles then 0 -> is_waiting stays 1 throughout; no run_start and no abort.
REQ-036 17 consecutive matching cycles -> is_waiting_ending=1 after edges 4..16; abort=1 and is_waiting=1 after edge 17; 16 matches then 0 -> RUNNING.
REQ-037 en toggled 1/0 every cycle during matching and run -> transitions and run_cnt advance only on en=1 edges; pulses stay single-cycle.
REQ-038 rearm=1 with run_cnt=3, then separately rst_n=0 mid-RUNNING -> both give is_waiting=1 and run_cnt=0 with no abort; rearm acts at the next edge, reset acts asynchronously.
REQ-039 MIN_MATCH=1, RUN_LEN=0 build with 1 match then 0 -> RUNNING after 2 edges; run_cnt saturates at 255 and the block stays in RUNNING.
